// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The master side supplies operands and consumes results; the slave side is the arithmetic unit.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             cb;
    logic             ov;

    modport master (
        output in_valid, a, b, op, sat, out_ready,
        input  in_ready, out_valid, d, cb, ov
    );

    modport slave (
        input  in_valid, a, b, op, sat, out_ready,
        output in_ready, out_valid, d, cb, ov
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one CW-bit chunk per stage, LSB chunk first, carry registered between
// stages. Operands ride along in skew registers; the last stage registers the final result.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic             w_en;
    logic             w_vld_in [STAGES];
    logic             w_op_in  [STAGES];
    logic             w_sat_in [STAGES];
    logic             w_c_in   [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_res_in [STAGES];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_cb;
    logic             r_ov;

    // A full output register refused by the consumer freezes every stage.
    assign w_en          = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.d         = r_d;
    assign bus.cb        = r_cb;
    assign bus.ov        = r_ov;

    assign w_vld_in[0] = bus.in_valid;
    assign w_op_in[0]  = bus.op;
    assign w_sat_in[0] = bus.sat;
    assign w_c_in[0]   = ~bus.op;
    assign w_a_in[0]   = bus.a;
    assign w_b_in[0]   = bus.b;
    assign w_res_in[0] = {WIDTH{1'b0}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      w_sum;
        logic [WIDTH-1:0] w_res;

        // Chunk k of the result (subtract uses a + ~b + carry), spliced into the partial result.
        always_comb begin
            w_sum = {1'b0, w_a_in[k][k*CW +: CW]}
                  + {1'b0, (w_op_in[k] ? w_b_in[k][k*CW +: CW] : ~w_b_in[k][k*CW +: CW])}
                  + {{CW{1'b0}}, w_c_in[k]};
            w_res = w_res_in[k];
            w_res[k*CW +: CW] = w_sum[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_vld;
            logic             r_op;
            logic             r_sat;
            logic             r_c;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_res;

            // Intermediate stage register: carry, operands and partial result advance together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_op  <= 1'b0;
                    r_sat <= 1'b0;
                    r_c   <= 1'b0;
                    r_a   <= {WIDTH{1'b0}};
                    r_b   <= {WIDTH{1'b0}};
                    r_res <= {WIDTH{1'b0}};
                end else if (w_en) begin
                    r_vld <= w_vld_in[k];
                    r_op  <= w_op_in[k];
                    r_sat <= w_sat_in[k];
                    r_c   <= w_sum[CW];
                    r_a   <= w_a_in[k];
                    r_b   <= w_b_in[k];
                    r_res <= w_res;
                end
            end

            assign w_vld_in[k+1] = r_vld;
            assign w_op_in[k+1]  = r_op;
            assign w_sat_in[k+1] = r_sat;
            assign w_c_in[k+1]   = r_c;
            assign w_a_in[k+1]   = r_a;
            assign w_b_in[k+1]   = r_b;
            assign w_res_in[k+1] = r_res;
        end else begin : g_last
            logic             w_cb;
            logic             w_ov;
            logic             w_a_msb;
            logic             w_b_msb;
            logic             w_r_msb;
            logic [WIDTH-1:0] w_d;

            // Carry/borrow out, signed overflow on the raw result, then optional saturation.
            always_comb begin
                w_a_msb = w_a_in[k][WIDTH-1];
                w_b_msb = w_b_in[k][WIDTH-1];
                w_r_msb = w_res[WIDTH-1];
                w_cb    = w_op_in[k] ? w_sum[CW] : ~w_sum[CW];
                if (w_op_in[k]) begin
                    w_ov = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
                end else begin
                    w_ov = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
                end
                if (w_sat_in[k] && w_cb) begin
                    w_d = w_op_in[k] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                end else begin
                    w_d = w_res;
                end
            end

            // Output register; holds steady while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_d         <= {WIDTH{1'b0}};
                    r_cb        <= 1'b0;
                    r_ov        <= 1'b0;
                end else if (w_en) begin
                    r_out_valid <= w_vld_in[k];
                    r_d         <= w_d;
                    r_cb        <= w_cb;
                    r_ov        <= w_ov;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vectors, stall/reset sequences and randomized
// traffic on four configurations, checked against an integer-arithmetic reference model.
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Lanes: 0 = 16b/4 stages, 1 = 4b/4 stages, 2 = 16b/16 stages, 3 = 16b/1 stage.
    logic [3:0]       t_in_valid;
    logic [3:0]       t_op;
    logic [3:0]       t_sat;
    logic [3:0]       t_out_ready;
    logic [3:0][15:0] t_a;
    logic [3:0][15:0] t_b;
    wire  [3:0]       t_in_ready;
    wire  [3:0]       t_out_valid;
    wire  [3:0]       t_cb;
    wire  [3:0]       t_ov;
    wire  [3:0][15:0] t_d;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam int W = (i == 1) ? 4 : 16;
        localparam int S = (i == 2) ? 16 : ((i == 3) ? 1 : 4);
        addsub_pipe_if #(.WIDTH(W)) bus ();
        addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign bus.in_valid  = t_in_valid[i];
        assign bus.a         = t_a[i][W-1:0];
        assign bus.b         = t_b[i][W-1:0];
        assign bus.op        = t_op[i];
        assign bus.sat       = t_sat[i];
        assign bus.out_ready = t_out_ready[i];
        assign t_in_ready[i] = bus.in_ready;
        assign t_out_valid[i] = bus.out_valid;
        assign t_d[i]        = 16'(bus.d);
        assign t_cb[i]       = bus.cb;
        assign t_ov[i]       = bus.ov;
    end

    typedef struct packed { logic [15:0] d; logic cb; logic ov; } res_t;
    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic        sat;
        logic [15:0] d;
        logic        cb;
        logic        ov;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lane_w(input int l);
        return (l == 1) ? 4 : 16;
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
    function automatic res_t model(input int w, input int unsigned a, input int unsigned b,
                                   input bit op, input bit sat);
        res_t        r;
        int unsigned mask;
        int unsigned raw;
        int          sa;
        int          sb;
        int          sr;
        mask = (32'd1 << w) - 32'd1;
        sa = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        if (op) begin
            raw  = a + b;
            r.cb = (raw > mask);
            sr   = sa + sb;
        end else begin
            raw  = a - b;
            r.cb = (a < b);
            sr   = sa - sb;
        end
        r.ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
        r.d  = 16'(raw & mask);
        if (sat && r.cb) r.d = op ? 16'(mask) : 16'd0;
        return r;
    endfunction

    // One transfer on lane 0 with out_ready=1: result must appear exactly 4 edges later.
    task automatic directed(input vec_t v);
        @(negedge clk);
        t_out_ready[0] = 1'b1;
        t_in_valid[0] = 1'b1;
        t_a[0] = v.a; t_b[0] = v.b; t_op[0] = v.op; t_sat[0] = v.sat;
        #1 check({v.nm, "_in_ready"}, t_in_ready[0], 1);
        @(negedge clk);
        t_in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check({v.nm, "_early"}, t_out_valid[0], 0);
        @(negedge clk);
        check({v.nm, "_valid"}, t_out_valid[0], 1);
        check({v.nm, "_d"}, t_d[0], v.d);
        check({v.nm, "_cb"}, t_cb[0], v.cb);
        check({v.nm, "_ov"}, t_ov[0], v.ov);
        @(negedge clk);
    endtask

    // mode 0: random traffic; 1: exhaustive operands; 2: back-to-back with a 3-cycle stall.
    task automatic run(input int lane, input int mode, input int n, input string tag);
        res_t        q[$];
        res_t        e;
        res_t        snap;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          stall = 0;
        bit          stalled = 1'b0;
        bit          have = 1'b0;
        int          w = lane_w(lane);
        int unsigned mask = (32'd1 << w) - 32'd1;
        int unsigned av = 0;
        int unsigned bv = 0;
        bit          opv = 1'b0;
        bit          satv = 1'b0;
        snap = '0;
        while ((sent < n || got < n) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check({tag, "_stall_valid"}, t_out_valid[lane], 1);
                check({tag, "_stall_hold"}, {t_d[lane], t_cb[lane], t_ov[lane]}, snap);
            end
            if (mode == 2) begin
                if (t_out_valid[lane] && stall < 3) begin
                    t_out_ready[lane] = 1'b0;
                    stall++;
                end else begin
                    t_out_ready[lane] = 1'b1;
                end
            end else begin
                t_out_ready[lane] = ($urandom_range(1) == 1);
            end
            if (!have && sent < n) begin
                have = 1'b1;
                if (mode == 0) begin
                    av = $urandom & mask; bv = $urandom & mask;
                    opv = $urandom_range(1) == 1; satv = $urandom_range(1) == 1;
                end else if (mode == 1) begin
                    av = sent % 16; bv = (sent / 16) % 16;
                    opv = ((sent / 256) % 2) == 1; satv = $urandom_range(1) == 1;
                end else begin
                    av = sent * 32'h1111; bv = sent;
                    opv = (sent % 2) == 1; satv = 1'b0;
                end
            end
            t_in_valid[lane] = (mode == 2) ? have : (have && ($urandom_range(1) == 1));
            t_a[lane] = 16'(av); t_b[lane] = 16'(bv); t_op[lane] = opv; t_sat[lane] = satv;
            #1;
            check({tag, "_in_ready"}, t_in_ready[lane], !(t_out_valid[lane] && !t_out_ready[lane]));
            if (t_out_valid[lane] && t_out_ready[lane]) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL %s_extra: got unexpected result d=%0h expected no result", tag, t_d[lane]);
                end else begin
                    e = q.pop_front();
                    check({tag, "_d"}, t_d[lane], e.d);
                    check({tag, "_cb"}, t_cb[lane], e.cb);
                    check({tag, "_ov"}, t_ov[lane], e.ov);
                    got++;
                end
            end
            stalled = t_out_valid[lane] && !t_out_ready[lane];
            snap.d = t_d[lane]; snap.cb = t_cb[lane]; snap.ov = t_ov[lane];
            if (t_in_valid[lane] && t_in_ready[lane]) begin
                q.push_back(model(w, av, bv, opv, satv));
                sent++;
                have = 1'b0;
            end
        end
        check({tag, "_received"}, got, n);
        check({tag, "_leftover"}, q.size(), 0);
        @(negedge clk);
        t_in_valid[lane] = 1'b0;
        t_out_ready[lane] = 1'b1;
    endtask

    vec_t vt[10];
    vec_t v9m4;

    initial begin
        bit seen;
        t_in_valid = '0; t_op = '0; t_sat = '0; t_out_ready = '1; t_a = '0; t_b = '0;
        vt[0] = '{"sub_5_3",     16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vt[1] = '{"sub_3_5",     16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vt[2] = '{"sub_3_5_sat", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{"sub_borrow",  16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vt[4] = '{"add_wrap",    16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{"add_wrap_sat",16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vt[6] = '{"add_ov",      16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[7] = '{"sub_ov",      16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vt[8] = '{"sub_zero",    16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[9] = '{"add_neg_sat", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        v9m4  = '{"sub_9_4",     16'h0009, 16'h0004, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};

        #12;
        check("rst_out_valid", t_out_valid[0], 0);
        check("rst_d", t_d[0], 0);
        check("rst_cb", t_cb[0], 0);
        check("rst_ov", t_ov[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", t_in_ready[0], 1);

        for (int i = 0; i < 10; i++) directed(vt[i]);

        run(0, 2, 8, "b2b_stall");

        // Reset while results are in flight: outputs clear at once and nothing stale emerges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            t_out_ready[0] = 1'b1; t_in_valid[0] = 1'b1;
            t_a[0] = 16'(i + 10); t_b[0] = 16'h0001; t_op[0] = 1'b0; t_sat[0] = 1'b0;
        end
        @(negedge clk);
        t_in_valid[0] = 1'b0;
        @(negedge clk);
        check("inflight_valid", t_out_valid[0], 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", t_out_valid[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (t_out_valid[0]) seen = 1'b1;
        end
        check("no_stale_result", seen, 0);
        directed(v9m4);

        run(0, 0, 1000, "rand_s4");
        run(1, 1, 512, "exh_w4");
        run(2, 0, 400, "rand_s16");
        run(3, 0, 400, "rand_s1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
